// File: rtl/mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// mult_ctrl_if -- handshake and strobe bundle between the shift-add
// multiplier controller and its datapath.
//
// Signals:
//   start    requester -> controller  begin one multiplication
//   b0       datapath  -> controller  LSB of the multiplier register
//   ld_ab    controller -> datapath   load operand registers
//   clr_p    controller -> datapath   clear product accumulator
//   mux_sel  controller -> datapath   0 = external operand, 1 = feedback
//   ld_p     controller -> datapath   product_hi += multiplicand
//   sh       controller -> datapath   shift product and multiplier
//   busy     controller status        operation in progress
//   done     controller status        one-cycle product-valid pulse
//   cnt      controller status        completed-iteration count
//
// Modports:
//   master : requester/datapath side (drives start, b0)
//   slave  : controller side (drives strobes and status)
// ---------------------------------------------------------------------------
interface mult_ctrl_if #(
  parameter int WIDTH = 4
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic          start;
  logic          b0;
  logic          ld_ab;
  logic          clr_p;
  logic          mux_sel;
  logic          ld_p;
  logic          sh;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  modport master (
    output start, b0,
    input  ld_ab, clr_p, mux_sel, ld_p, sh, busy, done, cnt
  );

  modport slave (
    input  start, b0,
    output ld_ab, clr_p, mux_sel, ld_p, sh, busy, done, cnt
  );
endinterface

// File: rtl/mult_ctrl.sv
// ---------------------------------------------------------------------------
// mult_ctrl -- control FSM for a WIDTH-bit shift-add multiplier.
//
// Sequence per operation:
//   IDLE -> LOAD -> { TEST -> [ADD] -> SHIFT } x WIDTH -> DONE -> IDLE
// ADD is visited only when the multiplier LSB (b0) is 1 at TEST.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears state, cnt and all outputs
//   bus    mult_ctrl_if.slave: start/b0 in, strobes/busy/done/cnt out
//
// Outputs are Moore: each output register is loaded with the decode of the
// next state, so its value in a cycle is a pure function of the current
// state and no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic ld_ab_q, clr_p_q, mux_sel_q, ld_p_q, sh_q, busy_q, done_q;

  // Next-state and iteration-counter logic
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        state_d = S_TEST;
        cnt_d   = '0;
      end
      S_TEST:  state_d = bus.b0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_TEST;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      // Illegal encodings recover to IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and output registers. Outputs follow the state being
  // entered so that they line up with state_q in the following cycle.
  // mux_sel stays on the feedback path throughout TEST/ADD/SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_ab_q   <= 1'b0;
      clr_p_q   <= 1'b0;
      mux_sel_q <= 1'b0;
      ld_p_q    <= 1'b0;
      sh_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_ab_q   <= (state_d == S_LOAD);
      clr_p_q   <= (state_d == S_LOAD);
      mux_sel_q <= (state_d == S_TEST) || (state_d == S_ADD) ||
                   (state_d == S_SHIFT);
      ld_p_q    <= (state_d == S_ADD);
      sh_q      <= (state_d == S_SHIFT);
      busy_q    <= (state_d == S_LOAD) || (state_d == S_TEST) ||
                   (state_d == S_ADD)  || (state_d == S_SHIFT);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.ld_ab   = ld_ab_q;
  assign bus.clr_p   = clr_p_q;
  assign bus.mux_sel = mux_sel_q;
  assign bus.ld_p    = ld_p_q;
  assign bus.sh      = sh_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cnt     = cnt_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_ctrl -- bench for mult_ctrl (WIDTH = 4) driving a behavioural
// shift-add datapath. Table of operand pairs with hand-computed products and
// latencies, plus sequences for mid-operation reset, back-to-back operation
// and start toggling while busy.
// ---------------------------------------------------------------------------
module tb_mult_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mult_ctrl_if #(.WIDTH(4)) bus ();

  mult_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural datapath: A multiplicand, B multiplier, P product, C carry.
  logic [3:0] a_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic [3:0] a_q  = 4'h0;
  logic [3:0] b_q  = 4'h0;
  logic [7:0] p_q  = 8'h00;
  logic       c_q  = 1'b0;

  assign bus.b0 = b_q[0];

  always @(posedge clk) begin
    if (bus.ld_ab) a_q <= a_in;
    if (bus.ld_ab || bus.sh) b_q <= bus.mux_sel ? {1'b0, b_q[3:1]} : b_in;
    if (bus.clr_p) begin
      p_q <= 8'h00;
      c_q <= 1'b0;
    end else if (bus.ld_p) begin
      {c_q, p_q[7:4]} <= {1'b0, p_q[7:4]} + {1'b0, a_q};
    end else if (bus.sh) begin
      p_q <= {c_q, p_q[7:1]};
      c_q <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.ld_ab, bus.clr_p, bus.mux_sel, bus.ld_p, bus.sh,
                 bus.busy, bus.done, bus.cnt});
  endfunction

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    int         nadd;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  // One multiplication; results are sampled on falling edges. Cycle 1 is the
  // LOAD cycle following the start-sampling edge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit toggle,
                        output logic [7:0] prod, output int lat,
                        output int nldp, output int nsh, output int nldab,
                        output int cnt_at_done, output int busy_at_done,
                        output int bad);
    bit prev_ldp;
    prod = 8'h00; lat = -1; nldp = 0; nsh = 0; nldab = 0;
    cnt_at_done = -1; busy_at_done = -1; bad = 0; prev_ldp = 1'b0;
    @(negedge clk);
    a_in = a; b_in = b; bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.ld_p)  nldp++;
      if (bus.sh)    nsh++;
      if (bus.ld_ab) nldab++;
      if (prev_ldp && !bus.sh) bad++;
      if (bus.clr_p !== bus.ld_ab) bad++;
      if (bus.mux_sel !== (bus.busy && !bus.ld_ab)) bad++;
      prev_ldp = bus.ld_p;
      if (bus.done) begin
        lat = n; prod = p_q; cnt_at_done = int'(bus.cnt);
        busy_at_done = int'(bus.busy);
        bus.start = 1'b0;
        break;
      end
      bus.start = toggle ? n[0] : 1'b0;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] prod;
    int lat, nldp, nsh, nldab, cdone, bdone, bad;
    int hit, ndone;
    int dq [$];

    vecs[0] = '{a:4'hD, b:4'hA, prod:8'h82, nadd:2, lat:12};
    vecs[1] = '{a:4'hF, b:4'hF, prod:8'hE1, nadd:4, lat:14};
    vecs[2] = '{a:4'h5, b:4'h0, prod:8'h00, nadd:0, lat:10};
    vecs[3] = '{a:4'h7, b:4'h1, prod:8'h07, nadd:1, lat:11};
    vecs[4] = '{a:4'h3, b:4'h8, prod:8'h18, nadd:1, lat:11};
    vecs[5] = '{a:4'hF, b:4'h5, prod:8'h4B, nadd:2, lat:12};
    vecs[6] = '{a:4'h9, b:4'h6, prod:8'h36, nadd:2, lat:12};
    vecs[7] = '{a:4'h0, b:4'hF, prod:8'h00, nadd:4, lat:14};

    bus.start = 1'b0;

    // Reset state, including start asserted while in reset.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // Idle with start low: nothing moves.
    hit = 0;
    repeat (3) begin
      @(negedge clk);
      if (outs() != 0) hit++;
    end
    check("idle_quiet", hit, 0);

    // Table-driven operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, prod, lat, nldp, nsh, nldab,
             cdone, bdone, bad);
      check($sformatf("v%0d_product", i), int'(prod), int'(vecs[i].prod));
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_ld_p_count", i), nldp, vecs[i].nadd);
      check($sformatf("v%0d_sh_count", i), nsh, 4);
      check($sformatf("v%0d_ld_ab_count", i), nldab, 1);
      check($sformatf("v%0d_cnt_at_done", i), cdone, 3);
      check($sformatf("v%0d_busy_at_done", i), bdone, 0);
      check($sformatf("v%0d_strobe_errors", i), bad, 0);
    end

    // Reset during ADD of iteration 2 (cnt = 1).
    @(negedge clk);
    a_in = 4'hF; b_in = 4'hF; bus.start = 1'b1;
    @(posedge clk);
    hit = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ld_p && bus.cnt == 2'd1) begin
        hit = 1;
        break;
      end
    end
    check("rst_reached_add2", hit, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", outs(), 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    check("rst_no_done", ndone, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_after", outs(), 0);
    run_op(4'hD, 4'hA, 1'b0, prod, lat, nldp, nsh, nldab, cdone, bdone, bad);
    check("rst_fresh_product", int'(prod), 8'h82);
    check("rst_fresh_latency", lat, 12);

    // start toggled while busy: no change in sequence or timing.
    run_op(4'hB, 4'hD, 1'b1, prod, lat, nldp, nsh, nldab, cdone, bdone, bad);
    check("toggle_product", int'(prod), 8'h8F);
    check("toggle_latency", lat, 13);
    check("toggle_ld_ab_count", nldab, 1);
    check("toggle_strobe_errors", bad, 0);

    // start held high: back-to-back runs, one done every 11 cycles.
    @(negedge clk);
    a_in = 4'h3; b_in = 4'h0; bus.start = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      if (n == 40) bus.start = 1'b0;
      if (bus.done) dq.push_back(n);
    end
    check("b2b_done_count", dq.size(), 4);
    if (dq.size() > 0) check("b2b_first_done", dq[0], 10);
    for (int i = 1; i < dq.size(); i++)
      check($sformatf("b2b_period_%0d", i), dq[i] - dq[i-1], 11);
    check("b2b_final_idle", outs() & 32'h1FC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
